keypad_calc_core: RTL and testbench
===================================

// Module: keypad_calc_core
// PURPOSE
//  Parametrised fixed-point decimal calculator engine for the keypad/7-seg designs.
//  Consumes encoded key codes over a valid/ready handshake and accumulates an operand.
//  Applies chained + - x / operators and presents a signed, scaled value to the display path.
//  Replaces the in-top calculator FSM. Multiply and divide use one shared sequential
//  restoring divider instead of combinational dividers.
// PARAMETERS
//  MAX_DIGITS   4   max digits per operand (positive); negative operands allow MAX_DIGITS-1
//  FRAC_DIGITS  3   fixed-point scale: SCALE = 10**FRAC_DIGITS; max fractional digits entered
//  VAL_W        25  width of operand / display value (signed two's complement)
//  ACC_W        36  width of accumulator and divider datapath (signed)
// PORTS
//  clk             in   1      clock
//  rst_n           in   1      asynchronous active-low reset
//  key_valid       in   1      key_code valid (one pulse per debounced press)
//  key_code        in   4      0-9 digit, A plus, B minus, C mul, D div, E clear, F point
//  key_ready       out  1      core can accept a key (high only in READ)
//  disp_value      out  VAL_W  signed value x SCALE to show
//  disp_frac       out  1      decimal point has been entered for current operand
//  disp_is_result  out  1      disp_value holds a result, not an operand
//  error           out  1      sticky error flag
//  busy            out  1      divider running
// BEHAVIOUR
//  - Reset (async): state CLEAR. All outputs 0 except key_ready, which is 0.
//    All registers are cleared, including error.
//  - Handshake: a key is taken on the cycle where key_valid && key_ready. The core ignores
//    key_valid when key_ready=0. key_ready drops the cycle after acceptance.
//  - States: CLEAR -> READ. READ -> DIGIT | SIGN | POINT | OP | CLEAR, by key.
//    DIGIT/SIGN/POINT -> SHOW_ARG -> READ.
//    OP -> (pending + or -) CHECK. OP -> (pending x) MUL -> DIV_RUN -> CHECK.
//    OP -> (pending /) DIV_RUN -> CHECK.
//    CHECK -> SHOW_RES -> READ, or CHECK -> CLEAR with error set.
//  - Digit d:
//    - Integer part: arg = arg*10 + s*d*SCALE, where s = -1 if sign is negative.
//    - k-th fractional digit: arg += s*d*10**(FRAC_DIGITS-k).
//    - Digit count reaching its limit (MAX_DIGITS, or MAX_DIGITS-1 if negative) -> error.
//    - k > FRAC_DIGITS -> error.
//  - Point F: sets disp_frac. A second F on the same operand -> error.
//  - B with digit count 0: sets sign negative, and disp_value shows the negative operand.
//  - Operators chain:
//    - On A/B-op/C/D, the PENDING operator is applied as acc = acc OP arg.
//    - The new operator becomes pending. The first pending operator is + with acc=0.
//  - Mul: product = acc*arg (ACC_W, truncated), then product/SCALE on the divider.
//  - Div: (acc*SCALE)/arg. arg==0 -> error, and the divider is not started.
//  - Divider: one quotient bit per cycle; busy=1 for exactly ACC_W cycles.
//    Operates on magnitudes; the quotient is truncated toward zero, then the sign is applied.
//  - CHECK: error if acc > (10**MAX_DIGITS-1)*SCALE or acc < -(10**(MAX_DIGITS-1)-1)*SCALE.
//    Otherwise disp_value = acc[VAL_W-1:0] and disp_is_result=1.
//  - SHOW_RES clears arg, sign, point and digit count; acc and the pending operator are kept.
//  - Latency: digit/sign/point key accepted at cycle t -> disp_value valid at t+2, key_ready=1 at t+3.
//    Add/sub results follow the same timing. Div results at t+ACC_W+3; mul results at t+ACC_W+4.
//  - Error: error=1 and state CLEAR wipes everything except error. error clears on the next
//    accepted key, and that key is processed normally.
//  - E (clear): -> CLEAR. error is cleared, because E is an accepted key.
//  - Reset asserted while the divider is running aborts it immediately; no partial result
//    is shown.
// CONFIGURATION
//  SUB_OP_EN defined:
//    - B with digit count > 0 is the subtract operator (acc - arg) and goes to OP.
//    - B with digit count 0 sets the sign.
//  SUB_OP_EN undefined:
//    - B with digit count > 0 is consumed and ignored (no state change, no error).
//    - No subtract operator exists.
// TESTING
//  1. 1,2,A,3,A -> disp_value 12000 then 15000; disp_is_result=1; error=0.
//  2. 5,F,2,5,C,2,A -> operand 5250; result 10500; busy high exactly 36 cycles.
//  3. 7,D,0,A -> error=1; disp_value=0. The next key 4 -> error=0, disp_value 4000.
//  4. 9,9,9,9,9 -> error on the fifth digit. B,1,2,3 -> -123000. B,1,2,3,4 -> error.
//  5. F,1,F -> error. 9,9,9,9,C,2,A -> overflow error. rst_n low mid-divide -> all outputs 0.
//  6. SUB_OP_EN: 8,B,3,A -> 5000. Without the macro: 8,B,3,A -> 83000.
//     key_valid while busy is not accepted (key_ready=0).

Source files
------------

// File: rtl/keypad_calc_core.sv
// Fixed-point decimal calculator engine: key-driven operand entry, chained + - x / operators,
// shared sequential restoring divider. Define SUB_OP_EN to make B a subtract operator.
module keypad_calc_core #(
  parameter int unsigned MAX_DIGITS  = 4,
  parameter int unsigned FRAC_DIGITS = 3,
  parameter int unsigned VAL_W       = 25,
  parameter int unsigned ACC_W       = 36
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    key_valid,
  input  logic [3:0]              key_code,
  output logic                    key_ready,
  output logic signed [VAL_W-1:0] disp_value,
  output logic                    disp_frac,
  output logic                    disp_is_result,
  output logic                    error,
  output logic                    busy
);

  localparam int unsigned CntW  = $clog2(MAX_DIGITS + 1);
  localparam int unsigned FracW = $clog2(FRAC_DIGITS + 1);
  localparam int unsigned CycW  = $clog2(ACC_W);
  localparam longint Scale  = longint'(10) ** FRAC_DIGITS;
  localparam longint MaxRes = (longint'(10) ** MAX_DIGITS - 1) * Scale;
  localparam longint MinRes = -((longint'(10) ** (MAX_DIGITS - 1) - 1) * Scale);
  localparam logic signed [ACC_W-1:0] ScaleAcc = ACC_W'(Scale);
  localparam logic signed [ACC_W-1:0] MaxAcc   = ACC_W'(MaxRes);
  localparam logic signed [ACC_W-1:0] MinAcc   = ACC_W'(MinRes);
  localparam logic signed [VAL_W-1:0] ScaleVal = VAL_W'(Scale);
  localparam logic signed [VAL_W-1:0] TenVal   = VAL_W'(10);
  localparam logic [CntW-1:0]  MaxCnt  = CntW'(MAX_DIGITS);
  localparam logic [FracW-1:0] MaxFrac = FracW'(FRAC_DIGITS);
  localparam logic [CycW-1:0]  LastCyc = CycW'(ACC_W - 1);

  typedef enum logic [3:0] {
    StClear, StRead, StDigit, StSign, StPoint, StShowArg,
    StOp, StMul, StDivRun, StCheck, StShowRes
  } state_e;

  typedef enum logic [1:0] {OpAdd, OpSub, OpMul, OpDiv} op_e;

  state_e                  state_q, state_d;
  op_e                     pend_q, pend_d;
  logic [3:0]              key_q, key_d;
  logic signed [VAL_W-1:0] arg_q, arg_d, disp_q, disp_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic                    neg_q, neg_d, point_q, point_d, is_res_q, is_res_d, err_q, err_d;
  logic [CntW-1:0]         dig_cnt_q, dig_cnt_d;
  logic [FracW-1:0]        frac_cnt_q, frac_cnt_d;
  logic [ACC_W-1:0]        rem_q, rem_d, quo_q, quo_d, dvsr_q, dvsr_d;
  logic                    qneg_q, qneg_d;
  logic [CycW-1:0]         cyc_q, cyc_d;

  function automatic logic [ACC_W-1:0] mag(input logic signed [ACC_W-1:0] x);
    return x[ACC_W-1] ? -x : x;
  endfunction

  function automatic logic signed [VAL_W-1:0] pow10(input logic [FracW-1:0] e);
    logic signed [VAL_W-1:0] w;
    w = VAL_W'(1);
    for (int unsigned i = 0; i < FRAC_DIGITS; i++) begin
      if (i < 32'(e)) w = w * TenVal;
    end
    return w;
  endfunction

  logic signed [ACC_W-1:0] arg_ext, prod, dvd;
  logic signed [VAL_W-1:0] weight, term, sterm, arg_next;
  logic [CntW-1:0]         limit;
  logic [ACC_W:0]          shifted, trial;
  logic [ACC_W-1:0]        step_rem, step_quo;

  always_comb begin
    arg_ext  = ACC_W'(arg_q);
    prod     = acc_q * arg_ext;
    dvd      = acc_q * ScaleAcc;
    // k-th fractional digit weighs 10**(FRAC_DIGITS-k); integer digits weigh SCALE
    weight   = point_q ? pow10(FracW'(MaxFrac - frac_cnt_q - FracW'(1))) : ScaleVal;
    term     = VAL_W'($signed({1'b0, key_q})) * weight;
    sterm    = neg_q ? -term : term;
    arg_next = point_q ? arg_q + sterm : arg_q * TenVal + sterm;
    limit    = neg_q ? CntW'(MaxCnt - CntW'(1)) : MaxCnt;
    shifted  = {rem_q, quo_q[ACC_W-1]};
    trial    = shifted - {1'b0, dvsr_q};
    step_rem = trial[ACC_W] ? shifted[ACC_W-1:0] : trial[ACC_W-1:0];
    step_quo = {quo_q[ACC_W-2:0], ~trial[ACC_W]};
  end

  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    key_d      = key_q;
    arg_d      = arg_q;
    disp_d     = disp_q;
    acc_d      = acc_q;
    neg_d      = neg_q;
    point_d    = point_q;
    is_res_d   = is_res_q;
    err_d      = err_q;
    dig_cnt_d  = dig_cnt_q;
    frac_cnt_d = frac_cnt_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    dvsr_d     = dvsr_q;
    qneg_d     = qneg_q;
    cyc_d      = cyc_q;
    unique case (state_q)
      StClear: begin
        acc_d      = '0;
        arg_d      = '0;
        disp_d     = '0;
        neg_d      = 1'b0;
        point_d    = 1'b0;
        is_res_d   = 1'b0;
        dig_cnt_d  = '0;
        frac_cnt_d = '0;
        pend_d     = OpAdd;
        key_d      = '0;
        state_d    = StRead;
      end
      StRead: begin
        if (key_valid) begin
          err_d = 1'b0;
          key_d = key_code;
          case (key_code)
            4'hA, 4'hC, 4'hD: state_d = StOp;
            4'hB: begin
              if (dig_cnt_q == '0) state_d = StSign;
`ifdef SUB_OP_EN
              else state_d = StOp;
`else
              else state_d = StRead;
`endif
            end
            4'hE:    state_d = StClear;
            4'hF:    state_d = StPoint;
            default: state_d = StDigit;
          endcase
        end
      end
      StDigit: begin
        if (dig_cnt_q >= limit || (point_q && frac_cnt_q >= MaxFrac)) begin
          err_d   = 1'b1;
          state_d = StClear;
        end else begin
          arg_d      = arg_next;
          disp_d     = arg_next;
          is_res_d   = 1'b0;
          dig_cnt_d  = dig_cnt_q + CntW'(1);
          frac_cnt_d = point_q ? frac_cnt_q + FracW'(1) : frac_cnt_q;
          state_d    = StShowArg;
        end
      end
      StSign: begin
        neg_d    = 1'b1;
        disp_d   = arg_q;
        is_res_d = 1'b0;
        state_d  = StShowArg;
      end
      StPoint: begin
        if (point_q) begin
          err_d   = 1'b1;
          state_d = StClear;
        end else begin
          point_d  = 1'b1;
          disp_d   = arg_q;
          is_res_d = 1'b0;
          state_d  = StShowArg;
        end
      end
      StShowArg: state_d = StRead;
      StOp: begin
        case (key_q)
          4'hA:    pend_d = OpAdd;
          4'hB:    pend_d = OpSub;
          4'hC:    pend_d = OpMul;
          default: pend_d = OpDiv;
        endcase
        unique case (pend_q)
          OpAdd: begin acc_d = acc_q + arg_ext; state_d = StCheck; end
          OpSub: begin acc_d = acc_q - arg_ext; state_d = StCheck; end
          OpMul: state_d = StMul;
          OpDiv: begin
            if (arg_q == '0) begin
              err_d   = 1'b1;
              state_d = StClear;
            end else begin
              rem_d   = '0;
              quo_d   = mag(dvd);
              dvsr_d  = mag(arg_ext);
              qneg_d  = dvd[ACC_W-1] ^ arg_q[VAL_W-1];
              cyc_d   = '0;
              state_d = StDivRun;
            end
          end
          default: state_d = StClear;
        endcase
      end
      StMul: begin
        rem_d   = '0;
        quo_d   = mag(prod);
        dvsr_d  = mag(ScaleAcc);
        qneg_d  = prod[ACC_W-1];
        cyc_d   = '0;
        state_d = StDivRun;
      end
      StDivRun: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cyc_d = cyc_q + CycW'(1);
        if (cyc_q == LastCyc) begin
          acc_d   = qneg_q ? -step_quo : step_quo;
          state_d = StCheck;
        end
      end
      StCheck: begin
        if (acc_q > MaxAcc || acc_q < MinAcc) begin
          err_d   = 1'b1;
          state_d = StClear;
        end else begin
          disp_d   = acc_q[VAL_W-1:0];
          is_res_d = 1'b1;
          state_d  = StShowRes;
        end
      end
      StShowRes: begin
        arg_d      = '0;
        neg_d      = 1'b0;
        point_d    = 1'b0;
        dig_cnt_d  = '0;
        frac_cnt_d = '0;
        state_d    = StRead;
      end
      default: state_d = StClear;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StClear;
      pend_q     <= OpAdd;
      key_q      <= '0;
      arg_q      <= '0;
      disp_q     <= '0;
      acc_q      <= '0;
      neg_q      <= 1'b0;
      point_q    <= 1'b0;
      is_res_q   <= 1'b0;
      err_q      <= 1'b0;
      dig_cnt_q  <= '0;
      frac_cnt_q <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dvsr_q     <= '0;
      qneg_q     <= 1'b0;
      cyc_q      <= '0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      key_q      <= key_d;
      arg_q      <= arg_d;
      disp_q     <= disp_d;
      acc_q      <= acc_d;
      neg_q      <= neg_d;
      point_q    <= point_d;
      is_res_q   <= is_res_d;
      err_q      <= err_d;
      dig_cnt_q  <= dig_cnt_d;
      frac_cnt_q <= frac_cnt_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      dvsr_q     <= dvsr_d;
      qneg_q     <= qneg_d;
      cyc_q      <= cyc_d;
    end
  end

  assign key_ready      = (state_q == StRead);
  assign busy           = (state_q == StDivRun);
  assign disp_value     = disp_q;
  assign disp_frac      = point_q;
  assign disp_is_result = is_res_q;
  assign error          = err_q;

endmodule

// File: tb/tb_keypad_calc_core.sv
// Directed bench for keypad_calc_core: key sequences with hand-computed display values,
// latencies and busy lengths.
module tb_keypad_calc_core;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               key_valid;
  logic [3:0]         key_code;
  logic               key_ready;
  logic signed [24:0] disp_value;
  logic               disp_frac;
  logic               disp_is_result;
  logic               error;
  logic               busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  keypad_calc_core dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .key_valid      (key_valid),
    .key_code       (key_code),
    .key_ready      (key_ready),
    .disp_value     (disp_value),
    .disp_frac      (disp_frac),
    .disp_is_result (disp_is_result),
    .error          (error),
    .busy           (busy)
  );

  task automatic send(input logic [3:0] k);
    int g;
    g = 0;
    while (!key_ready && g < 300) begin
      @(negedge clk);
      g++;
    end
    if (!key_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL ready_timeout: key_ready=%0b required=1", key_ready);
    end
    key_code  = k;
    key_valid = 1'b1;
    @(posedge clk);
    #1 key_valid = 1'b0;
  endtask

  // Negedges after acceptance until key_ready, busy cycles seen, disp_value at the 2nd one
  task automatic settle(output int lat, output int bsy, output int d2);
    lat = 0; bsy = 0; d2 = 0;
    do begin
      @(negedge clk);
      lat++;
      if (busy) bsy++;
      if (lat == 2) d2 = disp_value;
    end while (!key_ready && lat < 300);
    if (!key_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL settle_timeout: key_ready=%0b required=1", key_ready);
    end
  endtask

  task automatic press(input logic [3:0] k);
    int a, b, c;
    send(k);
    settle(a, b, c);
  endtask

  task automatic keys(input string s);
    for (int i = 0; i < s.len(); i++) begin
      byte c;
      c = s[i];
      press((c <= 8'h39) ? 4'(c - 8'h30) : 4'(c - 8'h37));
    end
  endtask

  task automatic do_reset();
    key_valid = 1'b0;
    key_code  = 4'h0;
    rst_n     = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; key_valid = 1'b0; key_code = 4'h0;
    #12;
    n_cmp++; if (key_ready !== 1'b0) begin n_bad++;
      $display("FAIL reset_ready: got=%0b required=0", key_ready); end
    n_cmp++; if (disp_value !== 25'sd0) begin n_bad++;
      $display("FAIL reset_disp: got=%0d required=0", disp_value); end
    n_cmp++; if (disp_frac !== 1'b0) begin n_bad++;
      $display("FAIL reset_frac: got=%0b required=0", disp_frac); end
    n_cmp++; if (disp_is_result !== 1'b0) begin n_bad++;
      $display("FAIL reset_is_result: got=%0b required=0", disp_is_result); end
    n_cmp++; if (error !== 1'b0) begin n_bad++;
      $display("FAIL reset_error: got=%0b required=0", error); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++;
      $display("FAIL reset_busy: got=%0b required=0", busy); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (key_ready !== 1'b1) begin n_bad++;
      $display("FAIL reset_to_read: key_ready=%0b required=1", key_ready); end
  endtask

  task automatic test_add_chain();
    do_reset();
    keys("12");
    n_cmp++; if (disp_value !== 25'sd12000 || disp_is_result !== 1'b0) begin n_bad++;
      $display("FAIL add_operand: disp=%0d res=%0b required=12000/0", disp_value, disp_is_result); end
    keys("A");
    n_cmp++; if (disp_value !== 25'sd12000 || disp_is_result !== 1'b1) begin n_bad++;
      $display("FAIL add_first: disp=%0d res=%0b required=12000/1", disp_value, disp_is_result); end
    keys("3A");
    n_cmp++; if (disp_value !== 25'sd15000 || disp_is_result !== 1'b1 || error !== 1'b0) begin
      n_bad++;
      $display("FAIL add_chain: disp=%0d res=%0b err=%0b required=15000/1/0",
               disp_value, disp_is_result, error); end
  endtask

  task automatic test_digit_latency();
    int lat, bsy, d2;
    do_reset();
    send(4'h7);
    settle(lat, bsy, d2);
    n_cmp++; if (lat != 3) begin n_bad++;
      $display("FAIL digit_ready_latency: got=%0d required=3", lat); end
    n_cmp++; if (d2 != 7000) begin n_bad++;
      $display("FAIL digit_disp_latency: got=%0d required=7000", d2); end
  endtask

  task automatic test_mul();
    int lat, bsy, d2;
    do_reset();
    keys("5F25");
    n_cmp++; if (disp_value !== 25'sd5250 || disp_frac !== 1'b1) begin n_bad++;
      $display("FAIL mul_operand: disp=%0d frac=%0b required=5250/1", disp_value, disp_frac); end
    keys("C2");
    send(4'hA);
    settle(lat, bsy, d2);
    n_cmp++; if (lat != 41) begin n_bad++;
      $display("FAIL mul_latency: got=%0d required=41", lat); end
    n_cmp++; if (bsy != 36) begin n_bad++;
      $display("FAIL mul_busy_cycles: got=%0d required=36", bsy); end
    n_cmp++; if (disp_value !== 25'sd10500 || disp_is_result !== 1'b1 || disp_frac !== 1'b0) begin
      n_bad++;
      $display("FAIL mul_result: disp=%0d res=%0b frac=%0b required=10500/1/0",
               disp_value, disp_is_result, disp_frac); end
  endtask

  task automatic test_div();
    int lat, bsy, d2;
    do_reset();
    keys("9D4");
    send(4'hA);
    settle(lat, bsy, d2);
    n_cmp++; if (lat != 40) begin n_bad++;
      $display("FAIL div_latency: got=%0d required=40", lat); end
    n_cmp++; if (bsy != 36) begin n_bad++;
      $display("FAIL div_busy_cycles: got=%0d required=36", bsy); end
    n_cmp++; if (disp_value !== 25'sd2250) begin n_bad++;
      $display("FAIL div_result: got=%0d required=2250", disp_value); end
    do_reset();
    keys("10D3A");
    n_cmp++; if (disp_value !== 25'sd3333) begin n_bad++;
      $display("FAIL div_trunc_pos: got=%0d required=3333", disp_value); end
    do_reset();
    keys("B10D3A");
    n_cmp++; if (disp_value !== -25'sd3333) begin n_bad++;
      $display("FAIL div_trunc_neg: got=%0d required=-3333", disp_value); end
  endtask

  task automatic test_div_zero();
    do_reset();
    keys("7D0A");
    n_cmp++; if (error !== 1'b1 || disp_value !== 25'sd0) begin n_bad++;
      $display("FAIL div_zero: err=%0b disp=%0d required=1/0", error, disp_value); end
    keys("4");
    n_cmp++; if (error !== 1'b0 || disp_value !== 25'sd4000) begin n_bad++;
      $display("FAIL err_recover: err=%0b disp=%0d required=0/4000", error, disp_value); end
  endtask

  task automatic test_digit_limits();
    do_reset();
    keys("9999");
    n_cmp++; if (disp_value !== 25'sd9999000 || error !== 1'b0) begin n_bad++;
      $display("FAIL four_digits: disp=%0d err=%0b required=9999000/0", disp_value, error); end
    keys("9");
    n_cmp++; if (error !== 1'b1) begin n_bad++;
      $display("FAIL fifth_digit: err=%0b required=1", error); end
    keys("B123");
    n_cmp++; if (disp_value !== -25'sd123000 || error !== 1'b0) begin n_bad++;
      $display("FAIL neg_three: disp=%0d err=%0b required=-123000/0", disp_value, error); end
    keys("4");
    n_cmp++; if (error !== 1'b1) begin n_bad++;
      $display("FAIL neg_fourth: err=%0b required=1", error); end
    keys("F123");
    n_cmp++; if (disp_value !== 25'sd123 || disp_frac !== 1'b1) begin n_bad++;
      $display("FAIL frac_three: disp=%0d frac=%0b required=123/1", disp_value, disp_frac); end
    keys("4");
    n_cmp++; if (error !== 1'b1) begin n_bad++;
      $display("FAIL frac_fourth: err=%0b required=1", error); end
  endtask

  task automatic test_point_and_range();
    do_reset();
    keys("F1F");
    n_cmp++; if (error !== 1'b1) begin n_bad++;
      $display("FAIL double_point: err=%0b required=1", error); end
    keys("9999C2A");
    n_cmp++; if (error !== 1'b1 || disp_value !== 25'sd0) begin n_bad++;
      $display("FAIL mul_overflow: err=%0b disp=%0d required=1/0", error, disp_value); end
    do_reset();
    keys("9999A");
    n_cmp++; if (error !== 1'b0 || disp_value !== 25'sd9999000) begin n_bad++;
      $display("FAIL max_boundary: err=%0b disp=%0d required=0/9999000", error, disp_value); end
    do_reset();
    keys("B999A");
    n_cmp++; if (error !== 1'b0 || disp_value !== -25'sd999000) begin n_bad++;
      $display("FAIL min_boundary: err=%0b disp=%0d required=0/-999000", error, disp_value); end
    keys("B1A");
    n_cmp++; if (error !== 1'b1) begin n_bad++;
      $display("FAIL min_underflow: err=%0b required=1", error); end
  endtask

  task automatic test_reset_mid_divide();
    do_reset();
    keys("5C2");
    send(4'hA);
    repeat (10) @(negedge clk);
    n_cmp++; if (busy !== 1'b1) begin n_bad++;
      $display("FAIL mid_div_busy: got=%0b required=1", busy); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0 || key_ready !== 1'b0 || error !== 1'b0 ||
                 disp_value !== 25'sd0 || disp_is_result !== 1'b0 || disp_frac !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_outputs: busy=%0b rdy=%0b err=%0b disp=%0d res=%0b frac=%0b required=0",
               busy, key_ready, error, disp_value, disp_is_result, disp_frac); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    keys("3");
    n_cmp++; if (disp_value !== 25'sd3000 || disp_is_result !== 1'b0) begin n_bad++;
      $display("FAIL after_abort: disp=%0d res=%0b required=3000/0", disp_value, disp_is_result); end
  endtask

  task automatic test_sub_key();
    int exp_val;
`ifdef SUB_OP_EN
    exp_val = 5000;
`else
    exp_val = 83000;
`endif
    do_reset();
    keys("8B3A");
    n_cmp++; if (disp_value != exp_val || error !== 1'b0) begin n_bad++;
      $display("FAIL b_key: disp=%0d err=%0b required=%0d/0", disp_value, error, exp_val); end
  endtask

  task automatic test_busy_ignore();
    int  lat, bsy, d2;
    logic seen_ready;
    do_reset();
    keys("6D3");
    send(4'hA);
    repeat (5) @(negedge clk);
    key_code   = 4'h9;
    key_valid  = 1'b1;
    seen_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (key_ready !== 1'b0 || busy !== 1'b1) seen_ready = 1'b1;
    end
    key_valid = 1'b0;
    n_cmp++; if (seen_ready !== 1'b0) begin n_bad++;
      $display("FAIL busy_ready: key_ready/busy deviated=%0b required=0", seen_ready); end
    settle(lat, bsy, d2);
    n_cmp++; if (disp_value !== 25'sd2000 || disp_is_result !== 1'b1) begin n_bad++;
      $display("FAIL busy_result: disp=%0d res=%0b required=2000/1", disp_value, disp_is_result); end
  endtask

  task automatic test_clear();
    do_reset();
    keys("5E");
    n_cmp++; if (disp_value !== 25'sd0) begin n_bad++;
      $display("FAIL clear_disp: got=%0d required=0", disp_value); end
    keys("7D0A");
    keys("E");
    n_cmp++; if (error !== 1'b0 || disp_value !== 25'sd0) begin n_bad++;
      $display("FAIL clear_error: err=%0b disp=%0d required=0/0", error, disp_value); end
  endtask

  initial begin
    test_reset();
    test_add_chain();
    test_digit_latency();
    test_mul();
    test_div();
    test_div_zero();
    test_digit_limits();
    test_point_and_range();
    test_reset_mid_divide();
    test_sub_key();
    test_busy_ignore();
    test_clear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
